// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: the five Y86-64 pipeline registers (F predPC, D, E, M, W),
// plus a sticky processor-halt latch and saturating stall/bubble counters.
//
// Ports:
//   clk, rst_n                  rising-edge clock, asynchronous active-low reset
//   f_predPC                    next predicted PC from fetch
//   d_in / e_in / m_in / w_in   next-stage bundles from the stage logic
//   F_stall, D_stall,           hazard controls (stall holds, bubble injects NOP;
//   D_bubble, E_bubble          D_stall wins over D_bubble)
//   F_predPC                    registered predicted PC
//   D_out / E_out / M_out /     registered bundles, same layouts as the inputs
//   W_out
//   halted                      set once W holds a non-AOK stat; cleared by reset only
//   stall_cnt, bubble_cnt       saturating performance counters
//
// Bundle layouts (MSB first):
//   D {stat2, icode4, ifun4, rA4, rB4, valC64, valP64}                       146
//   E {stat2, icode4, ifun4, valC64, valA64, valB64, dstE4, dstM4, srcA4,
//      srcB4}                                                                218
//   M {stat2, icode4, cnd1, valE64, valA64, dstE4, dstM4}                    143
//   W {stat2, icode4, valE64, valM64, dstE4, dstM4}                          142
module pipe_stage_regs #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       f_predPC,
    input  logic [145:0]      d_in,
    input  logic [217:0]      e_in,
    input  logic [142:0]      m_in,
    input  logic [141:0]      w_in,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              E_bubble,
    output logic [63:0]       F_predPC,
    output logic [145:0]      D_out,
    output logic [217:0]      E_out,
    output logic [142:0]      M_out,
    output logic [141:0]      W_out,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] RNONE    = 4'hF;

    // Bubble = AOK NOP with every register ID set to RNONE and all values zero.
    localparam logic [145:0] D_BUBBLE = {STAT_AOK, INOP, 4'h0, RNONE, RNONE,
                                         64'h0, 64'h0};
    localparam logic [217:0] E_BUBBLE = {STAT_AOK, INOP, 4'h0, 64'h0, 64'h0, 64'h0,
                                         RNONE, RNONE, RNONE, RNONE};
    localparam logic [142:0] M_BUBBLE = {STAT_AOK, INOP, 1'b0, 64'h0, 64'h0,
                                         RNONE, RNONE};
    localparam logic [141:0] W_BUBBLE = {STAT_AOK, INOP, 64'h0, 64'h0,
                                         RNONE, RNONE};

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [63:0]      f_q,   f_d;
    logic [145:0]     d_q,   d_d;
    logic [217:0]     e_q,   e_d;
    logic [142:0]     m_q,   m_d;
    logic [141:0]     w_q,   w_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        f_d          = f_q;
        d_d          = d_q;
        e_d          = e_q;
        m_d          = m_q;
        w_d          = w_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        // W is checked before this edge's update, so W still loads on the
        // edge that raises halted and freezes from the following edge.
        halted_d     = halted_q | (w_q[141:140] != STAT_AOK);

        if (!halted_q) begin
            if (!F_stall) f_d = f_predPC;

            if (D_stall)       d_d = d_q;
            else if (D_bubble) d_d = D_BUBBLE;
            else               d_d = d_in;

            e_d = E_bubble ? E_BUBBLE : e_in;
            m_d = m_in;
            w_d = w_in;

            if ((F_stall | D_stall) && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            if ((D_bubble | E_bubble) && (bubble_cnt_q != '1))
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q          <= RESET_PC;
            d_q          <= D_BUBBLE;
            e_q          <= E_BUBBLE;
            m_q          <= M_BUBBLE;
            w_q          <= W_BUBBLE;
            halted_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            f_q          <= f_d;
            d_q          <= d_d;
            e_q          <= e_d;
            m_q          <= m_d;
            w_q          <= w_d;
            halted_q     <= halted_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign F_predPC   = f_q;
    assign D_out      = d_q;
    assign E_out      = e_q;
    assign M_out      = m_q;
    assign W_out      = w_q;
    assign halted     = halted_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs (RESET_PC=64'h100, CNT_W=4).
module tb_pipe_stage_regs;

    localparam logic [145:0] D_BUB = {2'b00, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
    localparam logic [217:0] E_BUB = {2'b00, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,
                                      4'hF, 4'hF, 4'hF, 4'hF};
    localparam logic [142:0] M_BUB = {2'b00, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};
    localparam logic [141:0] W_BUB = {2'b00, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};

    localparam logic [145:0] D1 = {2'b00, 4'h3, 4'h0, 4'hF, 4'h2, 64'h1234, 64'h10A};
    localparam logic [145:0] D2 = {2'b00, 4'h6, 4'h1, 4'h3, 4'h7, 64'h0, 64'h114};
    localparam logic [145:0] D3 = {2'b00, 4'h7, 4'h2, 4'hF, 4'hF, 64'h400, 64'h11D};
    localparam logic [217:0] E1 = {2'b00, 4'h2, 4'h0, 64'h0, 64'h55, 64'h0,
                                   4'h3, 4'hF, 4'h2, 4'hF};
    localparam logic [217:0] E2 = {2'b00, 4'h6, 4'h0, 64'h0, 64'h7, 64'h9,
                                   4'h3, 4'hF, 4'h1, 4'h3};
    localparam logic [217:0] E3 = {2'b00, 4'h5, 4'h0, 64'h10, 64'h0, 64'hA0,
                                   4'hF, 4'h4, 4'hF, 4'h6};
    localparam logic [142:0] M1 = {2'b00, 4'h3, 1'b1, 64'h99, 64'h0, 4'h1, 4'hF};
    localparam logic [142:0] M2 = {2'b00, 4'h6, 1'b0, 64'h1F, 64'h5, 4'h2, 4'hF};
    localparam logic [142:0] M3 = {2'b00, 4'h7, 1'b1, 64'h0, 64'h0, 4'hF, 4'hF};
    localparam logic [141:0] W1 = {2'b00, 4'h3, 64'hAB, 64'h0, 4'h0, 4'hF};
    localparam logic [141:0] W2 = {2'b00, 4'h5, 64'h0, 64'hCD, 4'hF, 4'h7};
    localparam logic [141:0] WH = {2'b01, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF};
    localparam logic [141:0] W4 = {2'b00, 4'h2, 64'h77, 64'h0, 4'h8, 4'hF};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   f_predPC;
    logic [145:0]  d_in;
    logic [217:0]  e_in;
    logic [142:0]  m_in;
    logic [141:0]  w_in;
    logic          F_stall, D_stall, D_bubble, E_bubble;
    logic [63:0]   F_predPC;
    logic [145:0]  D_out;
    logic [217:0]  E_out;
    logic [142:0]  M_out;
    logic [141:0]  W_out;
    logic          halted;
    logic [3:0]    stall_cnt, bubble_cnt;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    pipe_stage_regs #(.RESET_PC(64'h100), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .f_predPC(f_predPC),
        .d_in(d_in), .e_in(e_in), .m_in(m_in), .w_in(w_in),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .F_predPC(F_predPC), .D_out(D_out), .E_out(E_out), .M_out(M_out), .W_out(W_out),
        .halted(halted), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [217:0] obs, input logic [217:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic fs, input logic ds, input logic db, input logic eb);
        F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},  F_predPC, 64'h100);
        check({tag, "_D"},   D_out, D_BUB);
        check({tag, "_E"},   E_out, E_BUB);
        check({tag, "_M"},   M_out, M_BUB);
        check({tag, "_W"},   W_out, W_BUB);
        check({tag, "_hlt"}, halted, 1'b0);
        check({tag, "_sc"},  stall_cnt, 4'h0);
        check({tag, "_bc"},  bubble_cnt, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_ctl(0, 0, 0, 0);
        f_predPC = 64'h10A; d_in = D1; e_in = E1; m_in = M1; w_in = W1;

        // Reset state, released between edges.
        #12;
        rst_n = 1'b1;
        check_reset_state("rst");

        // First edge loads every stage.
        tick();
        check("ld_pc", F_predPC, 64'h10A);
        check("ld_D",  D_out, D1);
        check("ld_E",  E_out, E1);
        check("ld_M",  M_out, M1);
        check("ld_W",  W_out, W1);

        // Load-use: stall F/D, bubble E.
        set_ctl(1, 1, 0, 1);
        f_predPC = 64'h114; d_in = D2; e_in = E2; m_in = M2; w_in = W2;
        tick();
        check("lu_pc", F_predPC, 64'h10A);
        check("lu_D",  D_out, D1);
        check("lu_E",  E_out, E_BUB);
        check("lu_M",  M_out, M2);
        check("lu_W",  W_out, W2);
        check("lu_sc", stall_cnt, 4'h1);
        check("lu_bc", bubble_cnt, 4'h1);

        // Mispredict: bubble D and E.
        set_ctl(0, 0, 1, 1);
        m_in = M3;
        tick();
        check("mp_pc", F_predPC, 64'h114);
        check("mp_D",  D_out, D_BUB);
        check("mp_E",  E_out, E_BUB);
        check("mp_M",  M_out, M3);
        check("mp_sc", stall_cnt, 4'h1);
        check("mp_bc", bubble_cnt, 4'h2);

        // Plain load to populate D and E.
        set_ctl(0, 0, 0, 0);
        tick();
        check("nl_D",  D_out, D2);
        check("nl_E",  E_out, E2);
        check("nl_bc", bubble_cnt, 4'h2);

        // D_stall and D_bubble together: stall wins.
        set_ctl(0, 1, 1, 0);
        d_in = D3; e_in = E3;
        tick();
        check("sw_D",  D_out, D2);
        check("sw_E",  E_out, E3);
        check("sw_sc", stall_cnt, 4'h2);
        check("sw_bc", bubble_cnt, 4'h3);

        // Halt: non-AOK stat enters W at edge N.
        set_ctl(0, 0, 0, 0);
        w_in = WH;
        tick();
        check("hN_W",   W_out, WH);
        check("hN_hlt", halted, 1'b0);

        // Edge N+1: halted rises while every register still loads.
        f_predPC = 64'h200; d_in = D1; e_in = E1; m_in = M1; w_in = W4;
        tick();
        check("hN1_hlt", halted, 1'b1);
        check("hN1_W",   W_out, W4);
        check("hN1_pc",  F_predPC, 64'h200);
        check("hN1_D",   D_out, D1);

        // Frozen while halted, despite new inputs and asserted controls.
        set_ctl(1, 1, 1, 1);
        f_predPC = 64'h300; d_in = D3; e_in = E3; m_in = M2; w_in = W2;
        tick();
        tick();
        check("hz_pc",  F_predPC, 64'h200);
        check("hz_D",   D_out, D1);
        check("hz_E",   E_out, E1);
        check("hz_M",   M_out, M1);
        check("hz_W",   W_out, W4);
        check("hz_hlt", halted, 1'b1);
        check("hz_sc",  stall_cnt, 4'h2);
        check("hz_bc",  bubble_cnt, 4'h3);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("ar");
        set_ctl(1, 0, 0, 0);
        rst_n = 1'b1;

        // Saturation: F_stall held for 20 edges.
        repeat (14) tick();
        check("sat14", stall_cnt, 4'hE);
        tick();
        check("sat15", stall_cnt, 4'hF);
        repeat (5) tick();
        check("sat20",    stall_cnt, 4'hF);
        check("sat20_pc", F_predPC, 64'h100);
        check("sat20_bc", bubble_cnt, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
